// File: rtl/posit_pkg.sv
// Shared posit datapath definitions: encoder FSM states, default word width
// and a constant clog2 helper for counter/pointer sizing.
package posit_pkg;

  localparam int POSIT_BITS_DEF = 32;

  typedef enum logic [1:0] {IDLE, REGIME, MERGE, HOLD} enc_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/posit_regime_encoder_right_shifter.sv
// Logical right shifter: places the tail after the regime field and returns
// the shifted-out bits left-aligned (guard bit at MSB) for rounding.
module right_shifter #(
  parameter int BITS = 32,
  parameter int SW   = 6
) (
  input  logic [BITS-1:0] i_data,
  input  logic [SW-1:0]   i_shamt,
  output logic [BITS-1:0] o_data,
  output logic [BITS-1:0] o_drop
);

  logic [2*BITS-1:0] w_wide;

  assign w_wide = {i_data, {BITS{1'b0}}} >> i_shamt;
  assign o_data = w_wide[2*BITS-1:BITS];
  assign o_drop = w_wide[BITS-1:0];

endmodule

// File: rtl/posit_regime_encoder.sv
// Iterative posit packer: builds the regime run one bit per cycle, merges the
// tail and negates. Optional RNE rounding under `POSIT_ENC_ROUND_EN`.
module posit_regime_encoder
  import posit_pkg::*;
#(
  parameter int BITS = POSIT_BITS_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sign,
  input  logic            in_zero,
  input  logic [BITS-1:0] in_k,
  input  logic [BITS-1:0] in_tail,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_posit,
  output logic            out_sat
);

  localparam int CW = clog2(BITS + 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LEN_MAX  = CW'(BITS - 1);
  localparam logic [CW-1:0] PTR_TOP  = CW'(BITS - 2);
  localparam logic [BITS:0] RUN_ONE  = (BITS + 1)'(1);
  localparam logic [BITS:0] RUN_SAT  = (BITS + 1)'(BITS - 1);
  localparam logic [BITS:0] RUN_FULL = (BITS + 1)'(BITS - 2);

  enc_state_t r_state, w_next;

  logic            r_sign, r_zero, r_sat, r_rbit;
  logic [BITS-1:0] r_tail;
  logic [CW-1:0]   r_len, r_cnt, r_ptr;
  logic [BITS-2:0] r_body;
  logic            r_out_valid, r_out_sat;
  logic [BITS-1:0] r_out_posit;

  // Run magnitude in BITS+1 bits so that k = -2^(BITS-1) negates cleanly.
  logic [BITS:0]   w_kext, w_run;
  logic            w_sat_in;
  logic [CW-1:0]   w_len;

  assign w_kext   = {in_k[BITS-1], in_k};
  assign w_run    = in_k[BITS-1] ? (~w_kext + RUN_ONE) : (w_kext + RUN_ONE);
  assign w_sat_in = (w_run >= RUN_SAT);

  always_comb begin
    w_len = '0;
    if (!in_zero) begin
      if (w_run >= RUN_FULL) w_len = LEN_MAX;
      else                   w_len = CW'(w_run + RUN_ONE);
    end
  end

  // The last regime bit is the terminator unless the run saturated the body.
  logic            w_bit;
  logic [BITS-2:0] w_onehot;

  assign w_bit    = ((r_cnt == ONE) && !r_sat) ? ~r_rbit : r_rbit;
  assign w_onehot = {{(BITS-2){1'b0}}, 1'b1} << r_ptr;

  logic [BITS-1:0] w_tail_sh, w_drop;
  logic [CW-1:0]   w_shamt;

  assign w_shamt = r_len + ONE;

  right_shifter #(.BITS(BITS), .SW(CW)) u_rsh (
    .i_data  (r_tail),
    .i_shamt (w_shamt),
    .o_data  (w_tail_sh),
    .o_drop  (w_drop)
  );

  logic [BITS-2:0] w_body_m, w_body_r;
  logic [BITS-1:0] w_mag, w_result;
  logic            w_rnd;
  logic            w_unused;

  assign w_body_m = r_body | w_tail_sh[BITS-2:0];

`ifdef POSIT_ENC_ROUND_EN
  // Round to nearest even; maxpos never wraps and a saturated regime has no tail.
  assign w_rnd    = !r_sat && w_drop[BITS-1] && ((|w_drop[BITS-2:0]) || w_body_m[0])
                    && !(&w_body_m);
  assign w_unused = w_tail_sh[BITS-1];
`else
  assign w_rnd    = 1'b0;
  assign w_unused = ^{w_tail_sh[BITS-1], w_drop};
`endif

  assign w_body_r = w_body_m + {{(BITS-2){1'b0}}, w_rnd};
  assign w_mag    = {1'b0, w_body_r};
  assign w_result = r_zero ? '0 : (r_sign ? -w_mag : w_mag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = (w_len == '0) ? MERGE : REGIME;
      REGIME:  if (r_cnt == ONE) w_next = MERGE;
      MERGE:   w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_zero      <= 1'b0;
      r_sat       <= 1'b0;
      r_rbit      <= 1'b0;
      r_tail      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_body      <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_posit <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign <= in_sign;
          r_zero <= in_zero;
          r_sat  <= w_sat_in;
          r_rbit <= ~in_k[BITS-1];
          r_tail <= in_tail;
          r_len  <= w_len;
          r_cnt  <= w_len;
          r_ptr  <= PTR_TOP;
          r_body <= '0;
        end
        REGIME: begin
          r_body <= r_body | (w_bit ? w_onehot : '0);
          r_cnt  <= r_cnt - ONE;
          r_ptr  <= r_ptr - ONE;
        end
        MERGE: begin
          r_out_posit <= w_result;
          r_out_sat   <= r_sat && !r_zero;
          r_out_valid <= 1'b1;
        end
        HOLD: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_posit = r_out_posit;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_posit_regime_encoder.sv
// Directed bench for posit_regime_encoder at BITS=8, with a bit-queue model of
// the posit layout; honours POSIT_ENC_ROUND_EN if defined for the build.
module tb_posit_regime_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sign = 1'b0;
  logic       in_zero = 1'b0;
  logic [7:0] in_k = '0;
  logic [7:0] in_tail = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_posit;
  logic       out_sat;

  int errs = 0;
  int checks = 0;

  logic [7:0] exp_p;
  logic       exp_sat;
  int         exp_lat;
  logic       exp_ok = 1'b0;

  posit_regime_encoder #(.BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_k(in_k), .in_tail(in_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Posit layout as a bit stream: run bits, terminator, tail; first 7 bits form the body.
  function automatic void model(input int k, input logic [7:0] tail, input logic sg,
                                input logic zr, output logic [7:0] p,
                                output logic sat, output int lat);
    bit q[$];
    int run, body;
    bit guard, sticky;
    p = '0; sat = 1'b0; lat = 1;
    if (zr) return;
    run = (k >= 0) ? k + 1 : -k;
    for (int i = 0; i < run && i < 7; i++) q.push_back(bit'(k >= 0));
    if (run < 7) q.push_back(bit'(k < 0));
    lat = q.size() + 1;
    sat = (run >= 7);
    if (!sat) for (int i = 7; i >= 0; i--) q.push_back(tail[i]);
    body = 0;
    for (int i = 0; i < 7; i++) body = body * 2 + int'(q.pop_front());
`ifdef POSIT_ENC_ROUND_EN
    if (!sat && q.size() > 0) begin
      guard = q.pop_front();
      sticky = 1'b0;
      while (q.size() > 0) sticky |= q.pop_front();
      if (guard && (sticky || (body % 2 == 1)) && body != 127) body++;
    end
`else
    guard = 1'b0; sticky = guard;
`endif
    p = sg ? 8'(-body) : 8'(body);
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && exp_ok) begin
      chk("hold_posit", {24'b0, out_posit}, {24'b0, exp_p});
      chk("hold_sat", {31'b0, out_sat}, {31'b0, exp_sat});
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
  end

  task automatic do_req(input string name, input int k, input logic [7:0] tail,
                        input logic sg, input logic zr, input int lit, input int stall);
    int cyc;
    model(k, tail, sg, zr, exp_p, exp_sat, exp_lat);
    exp_ok = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_k = 8'(k); in_tail = tail; in_sign = sg; in_zero = zr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_k = 8'($urandom); in_tail = 8'($urandom); in_sign = 1'($urandom); in_zero = 1'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, exp_lat);
    if (lit >= 0) chk({name, "_literal"}, {24'b0, out_posit}, 32'(lit));
    repeat (stall) @(posedge clk);
    #1;
    if (stall > 0) begin
      chk({name, "_stall_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_stall_ready"}, {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_post_valid"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_post_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_posit", {24'b0, out_posit}, 32'd0);
    chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req("k0",      0,    8'hA0, 1'b0, 1'b0, 8'h54, 0);
    do_req("km2",    -2,    8'hC0, 1'b0, 1'b0, 8'h1C, 0);
    do_req("k6sat",   6,    8'hFF, 1'b0, 1'b0, 8'h7F, 0);
    do_req("k0neg",   0,    8'hA0, 1'b1, 1'b0, 8'hAC, 0);
    do_req("zero",    5,    8'hFF, 1'b1, 1'b1, 8'h00, 0);
`ifdef POSIT_ENC_ROUND_EN
    do_req("k1",      1,    8'hF8, 1'b0, 1'b0, 8'h70, 0);
    do_req("km1neg", -1,    8'hFF, 1'b1, 1'b0, 8'hC0, 0);
    do_req("stall",   2,    8'h30, 1'b0, 1'b0, 8'h72, 5);
`else
    do_req("k1",      1,    8'hF8, 1'b0, 1'b0, 8'h6F, 0);
    do_req("km1neg", -1,    8'hFF, 1'b1, 1'b0, 8'hC1, 0);
    do_req("stall",   2,    8'h30, 1'b0, 1'b0, 8'h71, 5);
`endif
    do_req("k5edge",  5,    8'h40, 1'b0, 1'b0, 8'h7E, 0);
    chk("k5edge_sat", {31'b0, out_sat}, 32'd0);
    do_req("km7sat", -7,    8'hFF, 1'b0, 1'b0, 8'h00, 0);
    do_req("kmin",   -128,  8'hFF, 1'b0, 1'b0, 8'h00, 0);
    do_req("kmax",    127,  8'h55, 1'b0, 1'b0, 8'h7F, 0);

    for (int i = 0; i < 24; i++)
      do_req("rand", $signed(8'($urandom_range(0, 255))), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), -1, int'($urandom_range(0, 2)));

    // Abort mid-REGIME with an asynchronous reset pulse.
    exp_ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_k = 8'd3; in_tail = 8'h00; in_sign = 1'b0; in_zero = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_output", {31'b0, out_valid}, 32'd0);
    do_req("after_rst", 0, 8'hA0, 1'b0, 1'b0, 8'h54, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
